// File: rtl/pack_narrow_to_wide.sv
// rtl/pack_narrow_to_wide.sv - narrow-to-wide stream packer with keep mask, last flush and registered output
module pack_narrow_to_wide #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int MSB_FIRST = 1,
    localparam int OUT_W    = IN_W * RATIO,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [RATIO-1:0] out_keep,
    output logic             out_last,
    output logic [CNT_W-1:0] fill_cnt
);

    logic [OUT_W-1:0] acc_data;
    logic [RATIO-1:0] acc_keep;
    logic [OUT_W-1:0] merged_data;
    logic [RATIO-1:0] merged_keep;
    logic [RATIO-1:0] lane_hot;
    logic             accept;
    logic             complete;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (fill_cnt == CNT_W'(RATIO - 1)));

    // Accumulator view with the incoming beat already dropped into its lane.
    always_comb begin
        lane_hot    = '0;
        merged_data = acc_data;
        for (int i = 0; i < RATIO; i++) begin
            if (fill_cnt == CNT_W'((MSB_FIRST != 0) ? (RATIO - 1 - i) : i)) begin
                lane_hot[i] = 1'b1;
            end
            if (lane_hot[i]) begin
                merged_data[i*IN_W +: IN_W] = in_data;
            end
        end
        merged_keep = acc_keep | lane_hot;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_data  <= '0;
            acc_keep  <= '0;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (complete) begin
            // A completing beat may coincide with a handshake; the new word simply replaces the old.
            out_valid <= 1'b1;
            out_data  <= merged_data;
            out_keep  <= merged_keep;
            out_last  <= in_last;
            acc_data  <= '0;
            acc_keep  <= '0;
            fill_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                acc_data <= merged_data;
                acc_keep <= merged_keep;
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pack_narrow_to_wide.sv
// tb/tb_pack_narrow_to_wide.sv - self-checking bench for pack_narrow_to_wide
module tb_pack_narrow_to_wide;

    localparam int RA = 2;
    localparam int MA = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        av = 1'b0, al = 1'b0, ar = 1'b0;
    logic [7:0]  ad = '0;
    logic        a_in_ready, a_out_valid, a_out_last;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_keep, a_fill;

    logic        bv = 1'b0, bl = 1'b0, br = 1'b0;
    logic [7:0]  bd = '0;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic        c_in_ready, c_out_valid, c_out_last;
    logic [31:0] b_out_data, c_out_data;
    logic [3:0]  b_out_keep, c_out_keep;
    logic [2:0]  b_fill, c_fill;

    pack_narrow_to_wide #(.IN_W(8), .RATIO(2), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(av), .in_ready(a_in_ready), .in_data(ad), .in_last(al),
        .out_valid(a_out_valid), .out_ready(ar), .out_data(a_out_data), .out_keep(a_out_keep),
        .out_last(a_out_last), .fill_cnt(a_fill));

    pack_narrow_to_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(bv), .in_ready(b_in_ready), .in_data(bd), .in_last(bl),
        .out_valid(b_out_valid), .out_ready(br), .out_data(b_out_data), .out_keep(b_out_keep),
        .out_last(b_out_last), .fill_cnt(b_fill));

    pack_narrow_to_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) dut_c (
        .clk(clk), .reset(reset), .in_valid(bv), .in_ready(c_in_ready), .in_data(bd), .in_last(bl),
        .out_valid(c_out_valid), .out_ready(br), .out_data(c_out_data), .out_keep(c_out_keep),
        .out_last(c_out_last), .fill_cnt(c_fill));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  ok;
        logic        ol;
        logic        ir;
        logic [1:0]  fc;
    } vec_t;

    vec_t tbl[11];

    // Reference packer: beats collected in arrival order, word formed by lane arithmetic.
    logic [7:0]  cur[$];
    logic [15:0] exp_d[$];
    logic [1:0]  exp_k[$];
    logic        exp_l[$];

    task automatic model_accept(input logic [7:0] beat, input logic last);
        logic [15:0] w;
        logic [1:0]  k;
        int lane;
        cur.push_back(beat);
        if (cur.size() == RA || last) begin
            w = '0;
            k = '0;
            for (int i = 0; i < cur.size(); i++) begin
                lane = (MA != 0) ? (RA - 1 - i) : i;
                w[lane*8 +: 8] = cur[i];
                k[lane] = 1'b1;
            end
            exp_d.push_back(w);
            exp_k.push_back(k);
            exp_l.push_back(last);
            cur.delete();
        end
    endtask

    task automatic check_handshake();
        if (a_out_valid && ar) begin
            if (exp_d.size() == 0) begin
                chk("rand_unexpected_word", 64'(a_out_data), 64'hDEAD);
            end else begin
                chk("rand_data", 64'(a_out_data), 64'(exp_d.pop_front()));
                chk("rand_keep", 64'(a_out_keep), 64'(exp_k.pop_front()));
                chk("rand_last", 64'(a_out_last), 64'(exp_l.pop_front()));
            end
        end
    endtask

    initial begin
        int beats;
        int cyc;
        logic acc_prev;
        logic acc;

        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd1};
        tbl[1]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 16'hA1B2, 2'b11, 1'b0, 1'b1, 2'd0};
        tbl[2]  = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 8'hD4, 1'b1, 1'b1, 1'b1, 16'hC3D4, 2'b11, 1'b1, 1'b1, 2'd0};
        tbl[4]  = '{1'b1, 8'hE5, 1'b1, 1'b1, 1'b1, 16'hE500, 2'b10, 1'b1, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'hE500, 2'b10, 1'b1, 1'b0, 2'd0};
        tbl[6]  = '{1'b1, 8'hF6, 1'b0, 1'b0, 1'b1, 16'hE500, 2'b10, 1'b1, 1'b0, 2'd0};
        tbl[7]  = '{1'b1, 8'hF6, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 16'hF607, 2'b11, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b1, 8'h18, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 2'd1};

        // Reset state
        #2;
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_data", 64'(a_out_data), 64'd0);
        chk("rst_keep", 64'(a_out_keep), 64'd0);
        chk("rst_last", 64'(a_out_last), 64'd0);
        chk("rst_fill", 64'(a_fill), 64'd0);
        chk("rst_b_valid", 64'(b_out_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Table-driven cycle vectors on the 8->16 packer
        for (int i = 0; i < 11; i++) begin
            av = tbl[i].v; ad = tbl[i].d; al = tbl[i].l; ar = tbl[i].r;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", i), 64'(a_out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_in_ready", i), 64'(a_in_ready), 64'(tbl[i].ir));
            chk($sformatf("tbl%0d_fill", i), 64'(a_fill), 64'(tbl[i].fc));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_data", i), 64'(a_out_data), 64'(tbl[i].od));
                chk($sformatf("tbl%0d_keep", i), 64'(a_out_keep), 64'(tbl[i].ok));
                chk($sformatf("tbl%0d_last", i), 64'(a_out_last), 64'(tbl[i].ol));
            end
        end
        av = 1'b0; al = 1'b0;

        // RATIO=4, both lane orders
        bv = 1'b1; br = 1'b1; bl = 1'b0;
        bd = 8'h11; @(posedge clk); #1;
        chk("b_fill1", 64'(b_fill), 64'd1);
        chk("c_fill1", 64'(c_fill), 64'd1);
        bd = 8'h22; @(posedge clk); #1;
        bd = 8'h33; @(posedge clk); #1;
        bd = 8'h44; @(posedge clk); #1;
        chk("b_full_valid", 64'(b_out_valid), 64'd1);
        chk("b_full_data", 64'(b_out_data), 64'h11223344);
        chk("b_full_keep", 64'(b_out_keep), 64'hF);
        chk("b_full_last", 64'(b_out_last), 64'd0);
        chk("c_full_data", 64'(c_out_data), 64'h44332211);
        chk("c_full_keep", 64'(c_out_keep), 64'hF);
        chk("c_full_fill", 64'(c_fill), 64'd0);
        bd = 8'h55; @(posedge clk); #1;
        chk("b_part_noword", 64'(b_out_valid), 64'd0);
        bd = 8'h66; bl = 1'b1; @(posedge clk); #1;
        chk("b_part_valid", 64'(b_out_valid), 64'd1);
        chk("b_part_data", 64'(b_out_data), 64'h55660000);
        chk("b_part_keep", 64'(b_out_keep), 64'b1100);
        chk("b_part_last", 64'(b_out_last), 64'd1);
        chk("b_part_fill", 64'(b_fill), 64'd0);
        chk("c_part_data", 64'(c_out_data), 64'h00006655);
        chk("c_part_keep", 64'(c_out_keep), 64'b0011);
        chk("c_part_last", 64'(c_out_last), 64'd1);
        bv = 1'b0; bl = 1'b0;

        // Backpressure: A holds 0x18 in its accumulator
        av = 1'b1; ad = 8'h29; ar = 1'b0;
        @(posedge clk); #1;
        chk("bp_load_valid", 64'(a_out_valid), 64'd1);
        chk("bp_load_data", 64'(a_out_data), 64'h1829);
        ad = 8'h3A;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_stall%0d_in_ready", i), 64'(a_in_ready), 64'd0);
            chk($sformatf("bp_stall%0d_data", i), 64'(a_out_data), 64'h1829);
            chk($sformatf("bp_stall%0d_valid", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("bp_stall%0d_fill", i), 64'(a_fill), 64'd0);
        end
        ar = 1'b1; #1;
        chk("bp_release_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(a_out_valid), 64'd0);
        chk("bp_release_fill", 64'(a_fill), 64'd1);
        ad = 8'h4B;
        @(posedge clk); #1;
        chk("bp_next_data", 64'(a_out_data), 64'h3A4B);
        chk("bp_next_keep", 64'(a_out_keep), 64'b11);
        av = 1'b0; ar = 1'b0;
        @(posedge clk); #1;
        chk("bp_hold_valid", 64'(a_out_valid), 64'd1);

        // Asynchronous reset with a word pending, then with a partial word
        #2 reset = 1'b0; #1;
        chk("arst_word_valid", 64'(a_out_valid), 64'd0);
        chk("arst_word_data", 64'(a_out_data), 64'd0);
        chk("arst_word_keep", 64'(a_out_keep), 64'd0);
        @(negedge clk) reset = 1'b1;
        av = 1'b1; ad = 8'h5C; ar = 1'b1;
        @(posedge clk); #1;
        chk("arst_part_fill_pre", 64'(a_fill), 64'd1);
        #2 reset = 1'b0; #1;
        chk("arst_part_fill", 64'(a_fill), 64'd0);
        @(negedge clk) reset = 1'b1;
        ad = 8'h6D; @(posedge clk); #1;
        ad = 8'h7E; @(posedge clk); #1;
        chk("arst_clean_valid", 64'(a_out_valid), 64'd1);
        chk("arst_clean_data", 64'(a_out_data), 64'h6D7E);
        chk("arst_clean_keep", 64'(a_out_keep), 64'b11);
        chk("arst_clean_last", 64'(a_out_last), 64'd0);
        av = 1'b0;
        @(posedge clk); #1;

        // Random throttling against the reference packer
        beats = 0;
        cyc = 0;
        acc_prev = 1'b0;
        while (beats < 10000 && cyc < 60000) begin
            if (!(av && !acc_prev)) begin
                av = ($urandom_range(0, 9) < 7);
                ad = 8'($urandom);
                al = ($urandom_range(0, 6) == 0);
            end
            ar = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            chk("rand_fill", 64'(a_fill), 64'(cur.size()));
            chk("rand_in_ready", 64'(a_in_ready), 64'(!a_out_valid || ar));
            acc = av && a_in_ready;
            check_handshake();
            if (acc) begin
                model_accept(ad, al);
                beats++;
            end
            acc_prev = acc;
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 60000) chk("rand_cycle_budget", 64'(beats), 64'd10000);
        av = 1'b0; ar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_handshake();
            @(posedge clk); #1;
        end
        chk("rand_words_left", 64'(exp_d.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
